// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared types and constants for the MIPS bus access unit.
//   kind_e  : request kind (fetch/load/store/reserved)
//   size_e  : access size (byte/half/word/partial-word)
//   state_e : access unit FSM states
//   BE_*    : reset-independent byte-lane constants
//   legal_req() : request legality check (size 11 legal only as a load with
//                 MIPS_BUS_UNALIGNED_EN defined)
package mips_bus_pkg;

  typedef enum logic [1:0] {
    KIND_FETCH = 2'b00,
    KIND_LOAD  = 2'b01,
    KIND_STORE = 2'b10,
    KIND_RSVD  = 2'b11
  } kind_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_PART = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUS  = 2'b01,
    S_DATA = 2'b10,
    S_RESP = 2'b11
  } state_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  function automatic logic legal_req(input kind_e kind, input size_e size,
                                     input logic [1:0] lo);
    logic ok;
    ok = 1'b1;
    if (kind == KIND_RSVD)                                   ok = 1'b0;
    if (size == SIZE_HALF && lo[0])                          ok = 1'b0;
    if ((size == SIZE_WORD || kind == KIND_FETCH) && lo != 2'b00) ok = 1'b0;
    if (size == SIZE_PART && kind != KIND_LOAD)              ok = 1'b0;
`ifndef MIPS_BUS_UNALIGNED_EN
    if (size == SIZE_PART)                                   ok = 1'b0;
`endif
    return ok;
  endfunction

endpackage

// File: rtl/mips_bus_lane_fmt.sv
// mips_bus_lane_fmt: combinational byte-lane formatter.
//   kind, size, sgn, lo : request attributes (lo = byte address bits [1:0])
//   wdata  -> wdata_lane : store data replicated onto all lanes
//   be                   : active byte lanes
//   rdata, merge -> rdata_fmt : extracted and zero/sign-extended load data,
//                               or LWL/LWR merge when MIPS_BUS_UNALIGNED_EN
import mips_bus_pkg::*;

module mips_bus_lane_fmt (
  input  kind_e       kind,
  input  size_e       size,
  input  logic        sgn,
  input  logic [1:0]  lo,
  input  logic [31:0] wdata,
  input  logic [31:0] merge,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_fmt
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  always_comb begin
    byte_sh    = rdata >> {lo, 3'b000};
    half_sh    = rdata >> {lo[1], 4'b0000};
    be         = BE_WORD;
    wdata_lane = wdata;
    rdata_fmt  = rdata;
    // Fetches are always full-word regardless of the size field.
    if (kind != KIND_FETCH) begin
      case (size)
        SIZE_BYTE: begin
          be         = BE_BYTE0 << lo;
          wdata_lane = {4{wdata[7:0]}};
          rdata_fmt  = {{24{sgn & byte_sh[7]}}, byte_sh[7:0]};
        end
        SIZE_HALF: begin
          be         = lo[1] ? BE_HALF_HI : BE_HALF_LO;
          wdata_lane = {2{wdata[15:0]}};
          rdata_fmt  = {{16{sgn & half_sh[15]}}, half_sh[15:0]};
        end
        SIZE_WORD: begin
          be = BE_WORD;
        end
        SIZE_PART: begin
`ifdef MIPS_BUS_UNALIGNED_EN
          if (sgn) begin
            // LWL: lanes 0..k land in the top of rt; shift by 8*(3-k) = 8*~k
            be        = {lo == 2'd3, lo[1], lo != 2'd0, 1'b1};
            rdata_fmt = (rdata << {~lo, 3'b000}) |
                        (merge & ~(32'hFFFF_FFFF << {~lo, 3'b000}));
          end else begin
            // LWR: lanes k..3 land in the bottom of rt
            be        = {1'b1, lo != 2'd3, ~lo[1], lo == 2'd0};
            rdata_fmt = byte_sh | (merge & ~(32'hFFFF_FFFF >> {lo, 3'b000}));
          end
`else
          // Rejected before any bus cycle; value never reaches rsp_data.
          be        = BE_NONE;
          rdata_fmt = merge;
`endif
        end
      endcase
    end
  end

endmodule

// File: rtl/mips_bus_access_unit.sv
// mips_bus_access_unit: single-outstanding MIPS core to Avalon-MM master.
//   clk, reset (async, active-low)
//   req_*     : core request (valid/ready handshake, kind, size, addr, data)
//   rsp_*     : one-cycle completion pulse with formatted data and error
//   address/read/write/waitrequest/writedata/byteenable/readdata : Avalon-MM
// Parameters: ADDR_W (address width), WAIT_LIMIT (waitrequest timeout).
// Optional feature: define MIPS_BUS_UNALIGNED_EN for LWL/LWR (size 11 loads).
import mips_bus_pkg::*;

module mips_bus_access_unit #(
  parameter int ADDR_W     = 32,
  parameter int WAIT_LIMIT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_kind,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_merge,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] address,
  output logic              write,
  output logic              read,
  input  logic              waitrequest,
  output logic [31:0]       writedata,
  output logic [3:0]        byteenable,
  input  logic [31:0]       readdata
);

  localparam logic [15:0] WAIT_LAST = 16'(WAIT_LIMIT - 1);

  state_e      state;
  kind_e       r_kind;
  size_e       r_size;
  logic        r_signed;
  logic [1:0]  r_lo;
  logic [31:0] r_wdata;
  logic [31:0] r_merge;
  logic [15:0] wait_cnt;

  logic        in_idle;
  logic        legal;
  kind_e       l_kind;
  size_e       l_size;
  logic        l_signed;
  logic [1:0]  l_lo;
  logic [31:0] l_wdata;
  logic [31:0] l_merge;
  logic [3:0]  l_be;
  logic [31:0] l_wdata_lane;
  logic [31:0] l_rdata_fmt;

  assign in_idle   = (state == S_IDLE);
  assign req_ready = in_idle;
  assign legal     = legal_req(kind_e'(req_kind), size_e'(req_size), req_addr[1:0]);

  // One formatter serves both phases: live request fields at accept (lanes,
  // store data) and the registered fields afterwards (load extraction).
  always_comb begin
    l_kind   = in_idle ? kind_e'(req_kind) : r_kind;
    l_size   = in_idle ? size_e'(req_size) : r_size;
    l_signed = in_idle ? req_signed        : r_signed;
    l_lo     = in_idle ? req_addr[1:0]     : r_lo;
    l_wdata  = in_idle ? req_wdata         : r_wdata;
    l_merge  = in_idle ? req_merge         : r_merge;
  end

  mips_bus_lane_fmt u_lane_fmt (
    .kind       (l_kind),
    .size       (l_size),
    .sgn        (l_signed),
    .lo         (l_lo),
    .wdata      (l_wdata),
    .merge      (l_merge),
    .rdata      (readdata),
    .be         (l_be),
    .wdata_lane (l_wdata_lane),
    .rdata_fmt  (l_rdata_fmt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      r_kind     <= KIND_FETCH;
      r_size     <= SIZE_BYTE;
      r_signed   <= 1'b0;
      r_lo       <= '0;
      r_wdata    <= '0;
      r_merge    <= '0;
      wait_cnt   <= '0;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_data   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          if (req_valid) begin
            r_kind   <= kind_e'(req_kind);
            r_size   <= size_e'(req_size);
            r_signed <= req_signed;
            r_lo     <= req_addr[1:0];
            r_wdata  <= req_wdata;
            r_merge  <= req_merge;
            wait_cnt <= '0;
            if (legal) begin
              state      <= S_BUS;
              address    <= {req_addr[ADDR_W-1:2], 2'b00};
              byteenable <= l_be;
              writedata  <= (req_kind == KIND_STORE) ? l_wdata_lane : '0;
              read       <= (req_kind != KIND_STORE);
              write      <= (req_kind == KIND_STORE);
            end else begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
            end
          end
        end
        S_BUS: begin
          if (!waitrequest) begin
            read  <= 1'b0;
            write <= 1'b0;
            if (r_kind == KIND_STORE) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_data  <= '0;
            end else begin
              state <= S_DATA;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            // This edge samples the WAIT_LIMIT-th consecutive stall.
            read      <= 1'b0;
            write     <= 1'b0;
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_DATA: begin
          state     <= S_RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_data  <= l_rdata_fmt;
        end
        S_RESP: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_bus_access_unit.sv
// Bench for mips_bus_access_unit: directed vector table, reset sequences and
// randomized transactions against a byte-level reference model.
module tb_mips_bus_access_unit;

  localparam int AW = 32;
  localparam int WL = 4;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_kind;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [31:0]   req_merge;
  logic          rsp_valid;
  logic [31:0]   rsp_data;
  logic          rsp_err;
  logic [AW-1:0] address;
  logic          write;
  logic          read;
  logic          waitrequest;
  logic [31:0]   writedata;
  logic [3:0]    byteenable;
  logic [31:0]   readdata;

  mips_bus_access_unit #(.ADDR_W(AW), .WAIT_LIMIT(WL)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_merge(req_merge),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .address(address), .write(write), .read(read), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int lat; int bus; logic err; logic [3:0] be;
    logic [31:0] addr; logic [31:0] wd; logic [31:0] data; logic is_store;
  } exp_t;

  typedef struct {
    int lat; int bus; logic err; logic [3:0] be;
    logic [31:0] addr; logic [31:0] wd; logic [31:0] data;
    logic stable; logic pulse_ok; logic ready;
  } obs_t;

  typedef struct {
    logic [1:0] kind; logic [1:0] size; logic sgn;
    logic [31:0] a; logic [31:0] w; logic [31:0] m; logic [31:0] r;
    int nwait; exp_t e;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [1:0] k, input logic [1:0] s, input logic g,
                               input logic [31:0] a, input logic [31:0] w,
                               input logic [31:0] m, input logic [31:0] r, input int n,
                               input int lat, input int bus, input logic err,
                               input logic [3:0] be, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [31:0] data);
    vec_t v;
    v.kind = k; v.size = s; v.sgn = g; v.a = a; v.w = w; v.m = m; v.r = r; v.nwait = n;
    v.e.lat = lat; v.e.bus = bus; v.e.err = err; v.e.be = be; v.e.addr = addr;
    v.e.wd = wd; v.e.data = data; v.e.is_store = (k == 2'b10);
    return v;
  endfunction

  // Reference model: derived from the access rules byte by byte.
  function automatic exp_t model(input logic [1:0] kind, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] a, input logic [31:0] w,
                                 input logic [31:0] m, input logic [31:0] r, input int nwait);
    exp_t e;
    int k, x;
    logic legal;
    logic [7:0] rb [4];
    logic [7:0] mb [4];
    logic [7:0] ob [4];
    k = int'(a[1:0]);
    legal = (kind != 2'b11) && !(size == 2'b01 && a[0]) &&
            !((size == 2'b10 || kind == 2'b00) && k != 0) &&
            !(size == 2'b11 && kind != 2'b01);
`ifndef MIPS_BUS_UNALIGNED_EN
    if (size == 2'b11) legal = 1'b0;
`endif
    e.is_store = (kind == 2'b10);
    e.wd = 32'h0; e.be = 4'h0; e.addr = 32'h0; e.data = 32'h0;
    if (!legal) begin
      e.lat = 1; e.bus = 0; e.err = 1'b1;
      return e;
    end
    e.addr = {a[31:2], 2'b00};
    if (kind == 2'b00 || size == 2'b10) e.be = 4'hF;
    else if (size == 2'b00) e.be = 4'(1 << k);
    else if (size == 2'b01) e.be = (k >= 2) ? 4'hC : 4'h3;
    else if (sgn) e.be = 4'((1 << (k + 1)) - 1);
    else e.be = 4'(15 - ((1 << k) - 1));
    if (size == 2'b00) e.wd = 32'(w[7:0]) * 32'h0101_0101;
    else if (size == 2'b01) e.wd = 32'(w[15:0]) * 32'h0001_0001;
    else e.wd = w;
    if (nwait >= WL) begin
      e.lat = WL + 1; e.bus = WL; e.err = 1'b1;
      return e;
    end
    e.bus = nwait + 1;
    e.err = 1'b0;
    e.lat = nwait + (e.is_store ? 2 : 3);
    if (e.is_store) return e;
    for (int i = 0; i < 4; i++) begin
      rb[i] = r[8*i +: 8];
      mb[i] = m[8*i +: 8];
    end
    if (kind == 2'b00 || size == 2'b10) e.data = r;
    else if (size == 2'b00) begin
      x = int'(rb[k]);
      if (sgn && x >= 128) x -= 256;
      e.data = 32'(x);
    end else if (size == 2'b01) begin
      x = int'(rb[k+1]) * 256 + int'(rb[k]);
      if (sgn && x >= 32768) x -= 65536;
      e.data = 32'(x);
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sgn) ob[i] = (i >= 3 - k) ? rb[i-(3-k)] : mb[i];
        else     ob[i] = (i <= 3 - k) ? rb[i+k]     : mb[i];
      end
      e.data = {ob[3], ob[2], ob[1], ob[0]};
    end
    return e;
  endfunction

  // Drives one request and plays the Avalon slave (nwait stalls, then
  // readdata only in the cycle after the read is accepted).
  task automatic run_txn(input logic [1:0] kind, input logic [1:0] size, input logic sgn,
                         input logic [31:0] a, input logic [31:0] w, input logic [31:0] m,
                         input logic [31:0] r, input int nwait, output obs_t o);
    int  waits;
    logic acc_rd;
    logic done;
    o.lat = -1; o.bus = 0; o.err = 1'b0; o.be = '0; o.addr = '0; o.wd = '0;
    o.data = '0; o.stable = 1'b1; o.pulse_ok = 1'b0;
    @(negedge clk);
    o.ready = req_ready;
    req_valid = 1'b1; req_kind = kind; req_size = size; req_signed = sgn;
    req_addr = a; req_wdata = w; req_merge = m;
    waitrequest = 1'($urandom); readdata = $urandom;
    @(posedge clk);
    waits = 0; acc_rd = 1'b0; done = 1'b0;
    for (int k = 1; k <= 60 && !done; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rsp_valid) begin
        o.lat = k; o.data = rsp_data; o.err = rsp_err; done = 1'b1;
      end else begin
        // Junk on the request side must be ignored while busy.
        req_valid = 1'($urandom); req_kind = 2'($urandom); req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_merge = $urandom;
        readdata = acc_rd ? r : $urandom;
        acc_rd = 1'b0;
        if (read || write) begin
          if (o.bus == 0) begin
            o.be = byteenable; o.addr = address; o.wd = writedata;
          end else if (o.be !== byteenable || o.addr !== address || o.wd !== writedata) begin
            o.stable = 1'b0;
          end
          o.bus++;
          if (waits < nwait) begin
            waitrequest = 1'b1; waits++;
          end else begin
            waitrequest = 1'b0; acc_rd = read;
          end
        end else begin
          waitrequest = 1'($urandom);
        end
        @(posedge clk);
      end
    end
    @(posedge clk);
    @(negedge clk);
    o.pulse_ok = !rsp_valid && req_ready && !read && !write && (rsp_data === o.data);
  endtask

  task automatic judge(input string tag, input obs_t o, input exp_t e);
    check({tag, "_ready"}, 32'(o.ready), 32'd1);
    check({tag, "_latency"}, 32'(o.lat), 32'(e.lat));
    check({tag, "_err"}, 32'(o.err), 32'(e.err));
    check({tag, "_data"}, o.data, e.data);
    check({tag, "_buscycles"}, 32'(o.bus), 32'(e.bus));
    if (e.bus > 0) begin
      check({tag, "_be"}, 32'(o.be), 32'(e.be));
      check({tag, "_addr"}, o.addr, e.addr);
      check({tag, "_stable"}, 32'(o.stable), 32'd1);
      if (e.is_store) check({tag, "_wdata"}, o.wd, e.wd);
    end
    check({tag, "_pulse_hold"}, 32'(o.pulse_ok), 32'd1);
  endtask

  vec_t tbl [16];
  obs_t ob;
  exp_t ex;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_kind = '0; req_size = '0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; req_merge = '0; waitrequest = 1'b0; readdata = '0;

    tbl[0]  = mkv(2'b01, 2'b10, 1'b0, 32'h104, 32'h0, 32'h0, 32'hDEADBEEF, 0,
                  3, 1, 1'b0, 4'hF, 32'h104, 32'h0, 32'hDEADBEEF);
    tbl[1]  = mkv(2'b01, 2'b00, 1'b1, 32'h103, 32'h0, 32'h0, 32'h80FF0000, 0,
                  3, 1, 1'b0, 4'h8, 32'h100, 32'h0, 32'hFFFFFF80);
    tbl[2]  = mkv(2'b01, 2'b00, 1'b0, 32'h103, 32'h0, 32'h0, 32'h80FF0000, 0,
                  3, 1, 1'b0, 4'h8, 32'h100, 32'h0, 32'h00000080);
    tbl[3]  = mkv(2'b10, 2'b01, 1'b0, 32'h202, 32'h1234, 32'h0, 32'h0, 3,
                  5, 4, 1'b0, 4'hC, 32'h200, 32'h12341234, 32'h0);
    tbl[4]  = mkv(2'b01, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 32'h0, 0,
                  1, 0, 1'b1, 4'h0, 32'h0, 32'h0, 32'h0);
    tbl[5]  = mkv(2'b01, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0, 32'h55555555, 100,
                  5, 4, 1'b1, 4'hF, 32'h40, 32'h0, 32'h0);
`ifdef MIPS_BUS_UNALIGNED_EN
    tbl[6]  = mkv(2'b01, 2'b11, 1'b1, 32'h1, 32'h0, 32'h11223344, 32'hAABBCCDD, 0,
                  3, 1, 1'b0, 4'h3, 32'h0, 32'h0, 32'hCCDD3344);
    tbl[12] = mkv(2'b01, 2'b11, 1'b0, 32'h2, 32'h0, 32'h11223344, 32'hAABBCCDD, 0,
                  3, 1, 1'b0, 4'hC, 32'h0, 32'h0, 32'h1122AABB);
`else
    tbl[6]  = mkv(2'b01, 2'b11, 1'b1, 32'h1, 32'h0, 32'h11223344, 32'hAABBCCDD, 0,
                  1, 0, 1'b1, 4'h0, 32'h0, 32'h0, 32'h0);
    tbl[12] = mkv(2'b01, 2'b11, 1'b0, 32'h2, 32'h0, 32'h11223344, 32'hAABBCCDD, 0,
                  1, 0, 1'b1, 4'h0, 32'h0, 32'h0, 32'h0);
`endif
    tbl[7]  = mkv(2'b11, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 0,
                  1, 0, 1'b1, 4'h0, 32'h0, 32'h0, 32'h0);
    tbl[8]  = mkv(2'b10, 2'b00, 1'b0, 32'h11, 32'hFFFFFFA5, 32'h0, 32'h0, 0,
                  2, 1, 1'b0, 4'h2, 32'h10, 32'hA5A5A5A5, 32'h0);
    tbl[9]  = mkv(2'b00, 2'b10, 1'b0, 32'h8, 32'h0, 32'h0, 32'h12345678, 0,
                  3, 1, 1'b0, 4'hF, 32'h8, 32'h0, 32'h12345678);
    tbl[10] = mkv(2'b00, 2'b10, 1'b0, 32'h2, 32'h0, 32'h0, 32'h0, 0,
                  1, 0, 1'b1, 4'h0, 32'h0, 32'h0, 32'h0);
    tbl[11] = mkv(2'b01, 2'b01, 1'b1, 32'h6, 32'h0, 32'h0, 32'h80017FFF, 0,
                  3, 1, 1'b0, 4'hC, 32'h4, 32'h0, 32'hFFFF8001);
    tbl[13] = mkv(2'b10, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 0,
                  1, 0, 1'b1, 4'h0, 32'h0, 32'h0, 32'h0);
    tbl[14] = mkv(2'b01, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0F0F0F0F, 3,
                  6, 4, 1'b0, 4'hF, 32'h10, 32'h0, 32'h0F0F0F0F);
    tbl[15] = mkv(2'b01, 2'b01, 1'b0, 32'h0, 32'h0, 32'h0, 32'h80017FFF, 0,
                  3, 1, 1'b0, 4'h3, 32'h0, 32'h0, 32'h00007FFF);

    // Reset state
    #12;
    check("rst_read", 32'(read), 32'd0);
    check("rst_write", 32'(write), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_address", address, 32'd0);
    check("rst_byteenable", 32'(byteenable), 32'd0);
    check("rst_writedata", writedata, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);

    // Release between edges so the first vector is accepted on the very next edge.
    @(posedge clk);
    #2 reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_txn(tbl[i].kind, tbl[i].size, tbl[i].sgn, tbl[i].a, tbl[i].w, tbl[i].m,
              tbl[i].r, tbl[i].nwait, ob);
      judge($sformatf("vec%0d", i), ob, tbl[i].e);
    end

    // Reset asserted in the middle of a stalled read.
    @(negedge clk);
    req_valid = 1'b1; req_kind = 2'b01; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h20; waitrequest = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("midrst_read_before", 32'(read), 32'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_read", 32'(read), 32'd0);
    check("midrst_address", address, 32'd0);
    check("midrst_byteenable", 32'(byteenable), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd1);
    #1 reset = 1'b1;
    waitrequest = 1'b0;
    run_txn(2'b01, 2'b10, 1'b0, 32'h24, 32'h0, 32'h0, 32'h13579BDF, 0, ob);
    judge("post_rst", ob, model(2'b01, 2'b10, 1'b0, 32'h24, 32'h0, 32'h0, 32'h13579BDF, 0));

    // Randomized transactions against the model.
    for (int t = 0; t < 300; t++) begin
      int sel, nw;
      logic [1:0] kd, sz;
      logic sg;
      logic [31:0] ad, wv, mv, rv;
      sel = $urandom_range(0, 9);
      kd  = (sel < 3) ? 2'b00 : (sel < 7) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
      sz  = 2'($urandom);
      sg  = 1'($urandom);
      ad  = $urandom; wv = $urandom; mv = $urandom; rv = $urandom;
      // Bias toward aligned addresses so most requests reach the bus.
      if ($urandom_range(0, 1) == 0) ad[1:0] = 2'b00;
      nw  = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 6);
      ex  = model(kd, sz, sg, ad, wv, mv, rv, nw);
      run_txn(kd, sz, sg, ad, wv, mv, rv, nw, ob);
      judge($sformatf("rnd%0d", t), ob, ex);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
